// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter in front of a single-port data memory; FSM walks IDLE -> CMD -> RSP.
// Latency: read 3 cycles from sampled request to rvalid, write occupies 2; a loser holds req until its gnt.
// ARB_ROUND_ROBIN_EN alternates ties against last_gnt; when undefined, requester 0 always wins ties.
module data_mem_arbiter #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, CMD, RSP} state_t;

    state_t            state_q, state_d;
    logic              last_gnt_q, last_gnt_d;
    logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              sel;

    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        sel = (req0 && req1) ? ~last_gnt_q : req1;
`else
        sel = req1 && !req0;
`endif
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        rvalid0_d   = 1'b0;
        rvalid1_d   = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        case (state_q)
            IDLE: begin
                // The memory command flops double as the registered command,
                // so a request that drops after sampling still completes.
                if (req0 || req1) begin
                    state_d     = CMD;
                    last_gnt_d  = sel;
                    gnt0_d      = ~sel;
                    gnt1_d      = sel;
                    mem_en_d    = 1'b1;
                    mem_we_d    = sel ? we1 : we0;
                    mem_addr_d  = sel ? addr1 : addr0;
                    mem_wdata_d = sel ? wdata1 : wdata0;
                end
            end
            CMD: begin
                state_d   = mem_we_q ? IDLE : RSP;
                rvalid0_d = ~mem_we_q & ~last_gnt_q;
                rvalid1_d = ~mem_we_q & last_gnt_q;
            end
            RSP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            last_gnt_q  <= 1'b1;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    // Memory data only arrives in the RSP cycle, so it is passed through, not registered.
    assign rdata     = (rvalid0_q | rvalid1_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed latency/reset cases plus random two-port traffic,
// checked by a negedge monitor against per-requester command queues and a reference memory.
`timescale 1ns/100ps
module tb_data_mem_arbiter;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
    logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
    logic              gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we;
    logic [DATA_W-1:0] rdata, mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [ADDR_W-1:0] mem_addr;

    data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;
    typedef struct {
        int                who;
        logic [DATA_W-1:0] data;
        int                due;
    } rsp_t;

    cmd_t              cmd_q0[$], cmd_q1[$];
    rsp_t              rsp_q[$];
    int                grant_log[$];
    logic [DATA_W-1:0] dev_mem[8];
    logic [DATA_W-1:0] ref_mem[8];
    int                checks = 0, failures = 0, cyc = 0;
    int                model_last = 1;
    bit                prev_r0 = 1'b0, prev_r1 = 1'b0;
    bit                granted[2];
    int                mon_w, mon_ew;
    cmd_t              mon_c;
    rsp_t              mon_r;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, mem_addr, mem_wdata, rdata}, 64'd0);
    endtask

    task automatic issue(input int r, input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        cmd_t c;
        c.we = we; c.addr = a; c.wdata = d;
        if (r == 0) begin
            req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; cmd_q0.push_back(c);
        end else begin
            req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; cmd_q1.push_back(c);
        end
    endtask

    task automatic drop(input int r);
        if (r == 0) req0 = 1'b0;
        else req1 = 1'b0;
    endtask

    task automatic flush_model();
        cmd_q0.delete(); cmd_q1.delete(); rsp_q.delete(); grant_log.delete();
        model_last = 1; granted[0] = 1'b0; granted[1] = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        drop(0); drop(1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("outputs_in_reset");
        reset = 1'b0;
        flush_model();
    endtask

    // Each requester holds its command until granted, then waits 0..gap_max cycles before the next.
    task automatic run_traffic(input int n0, input int n1, input int wr_pct, input int gap_max);
        int rem[2];
        int gap[2];
        bit active[2];
        int budget;
        rem[0] = n0; rem[1] = n1; gap[0] = 0; gap[1] = 0;
        active[0] = 1'b0; active[1] = 1'b0;
        granted[0] = 1'b0; granted[1] = 1'b0;
        budget = (n0 + n1) * 8 + 50;
        while (budget > 0 && (rem[0] > 0 || rem[1] > 0 || active[0] || active[1] || rsp_q.size() > 0)) begin
            @(posedge clk); #1;
            budget--;
            for (int r = 0; r < 2; r++) begin
                if (active[r] && granted[r]) begin
                    granted[r] = 1'b0; active[r] = 1'b0; drop(r);
                    gap[r] = $urandom_range(gap_max, 0);
                end
                if (!active[r] && rem[r] > 0) begin
                    if (gap[r] == 0) begin
                        issue(r, $urandom_range(99, 0) < wr_pct, ADDR_W'($urandom_range(7, 0)), DATA_W'($urandom));
                        active[r] = 1'b1;
                        rem[r]--;
                    end else begin
                        gap[r]--;
                    end
                end
            end
        end
        if (budget == 0) chk("traffic_timeout", 64'd0, 64'd1);
        drop(0); drop(1);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory device model: acts on strobes at mid-cycle, read data held until the next read.
    always @(negedge clk) begin
        if (mem_en) begin
            if (mem_we) dev_mem[mem_addr] = mem_wdata;
            else mem_rdata = dev_mem[mem_addr];
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            chk("gnt_exclusive", {63'd0, gnt0 & gnt1}, 64'd0);
            chk("rvalid_exclusive", {63'd0, rvalid0 & rvalid1}, 64'd0);
            if (gnt0 || gnt1) begin
                mon_w = gnt1 ? 1 : 0;
                chk("grant_had_request", {63'd0, prev_r0 | prev_r1}, 64'd1);
                if (prev_r0 && prev_r1) begin
`ifdef ARB_ROUND_ROBIN_EN
                    mon_ew = 1 - model_last;
`else
                    mon_ew = 0;
`endif
                end else begin
                    mon_ew = prev_r1 ? 1 : 0;
                end
                chk("winner", mon_w, mon_ew);
                if ((mon_w == 0 && cmd_q0.size() == 0) || (mon_w == 1 && cmd_q1.size() == 0)) begin
                    chk("grant_without_cmd", 64'd0, 64'd1);
                end else begin
                    if (mon_w == 0) mon_c = cmd_q0.pop_front();
                    else mon_c = cmd_q1.pop_front();
                    chk("mem_cmd", {mem_en, mem_we, mem_addr}, {1'b1, mon_c.we, mon_c.addr});
                    if (mon_c.we) begin
                        chk("mem_wdata", mem_wdata, mon_c.wdata);
                        ref_mem[mon_c.addr] = mon_c.wdata;
                    end else begin
                        rsp_q.push_back('{mon_w, ref_mem[mon_c.addr], cyc + 1});
                    end
                end
                model_last = mon_w;
                grant_log.push_back(mon_w);
                granted[mon_w] = 1'b1;
            end else begin
                chk("mem_idle", {mem_en, mem_we, mem_addr, mem_wdata}, 64'd0);
            end
            if (rsp_q.size() > 0 && rsp_q[0].due < cyc) begin
                chk("rvalid_missing", 64'd0, 64'd1);
                void'(rsp_q.pop_front());
            end
            if (rvalid0 || rvalid1) begin
                if (rsp_q.size() == 0) begin
                    chk("rvalid_spurious", 64'd0, 64'd1);
                end else begin
                    mon_r = rsp_q.pop_front();
                    chk("rvalid_who", rvalid1 ? 1 : 0, mon_r.who);
                    chk("rdata", rdata, mon_r.data);
                    chk("rvalid_cycle", cyc, mon_r.due);
                end
            end
            prev_r0 = req0;
            prev_r1 = req1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            dev_mem[i] = DATA_W'($urandom);
            ref_mem[i] = dev_mem[i];
        end
        dev_mem[3] = 16'hA5A5; ref_mem[3] = 16'hA5A5;

        @(posedge clk); #2;
        chk_all_zero("reset_outputs");
        @(posedge clk); #1;
        reset = 1'b0;

        // Read from requester 0 at addr 3: gnt in cycle 2, rvalid with A5A5 in cycle 3.
        @(posedge clk); #1;
        issue(0, 1'b0, 3'd3, 16'h0);
        @(negedge clk); chk("rd_c1_no_gnt", {63'd0, gnt0}, 64'd0);
        @(negedge clk); chk("rd_c2_cmd", {gnt0, mem_en, mem_we, mem_addr}, {1'b1, 1'b1, 1'b0, 3'd3});
        @(posedge clk); #1; drop(0); granted[0] = 1'b0;
        @(negedge clk); chk("rd_c3_rvalid", {rvalid0, rdata}, {1'b1, 16'hA5A5});

        // Write from requester 1 at addr 7: gnt with command in cycle 2, then idle, no rvalid.
        @(posedge clk); #1;
        issue(1, 1'b1, 3'd7, 16'h1234);
        @(negedge clk); chk("wr_c1_no_gnt", {63'd0, gnt1}, 64'd0);
        @(negedge clk); chk("wr_c2_cmd", {gnt1, mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 1'b1, 3'd7, 16'h1234});
        @(posedge clk); #1; drop(1); granted[1] = 1'b0;
        @(negedge clk); chk("wr_c3_idle", {gnt0, gnt1, rvalid0, rvalid1, mem_en}, 64'd0);
        @(negedge clk); chk("wr_c4_no_rvalid", {gnt0, gnt1, rvalid0, rvalid1, mem_en}, 64'd0);

        // Read request dropped while in CMD still completes.
        @(posedge clk); #1;
        issue(0, 1'b0, 3'd5, 16'h0);
        @(posedge clk); #1; drop(0);
        @(negedge clk); chk("drop_gnt0", {63'd0, gnt0}, 64'd1);
        @(negedge clk); chk("drop_rvalid0", {rvalid0, rdata}, {1'b1, ref_mem[5]});
        granted[0] = 1'b0;

        // Both requesters streaming reads.
        apply_reset();
`ifdef ARB_ROUND_ROBIN_EN
        run_traffic(2, 2, 0, 0);
        chk("tie_order_len", grant_log.size(), 4);
        if (grant_log.size() == 4) chk("tie_order", {grant_log[0][0], grant_log[1][0], grant_log[2][0], grant_log[3][0]}, 64'b0101);
`else
        run_traffic(3, 1, 0, 0);
        chk("tie_order_len", grant_log.size(), 4);
        if (grant_log.size() == 4) chk("tie_order", {grant_log[0][0], grant_log[1][0], grant_log[2][0], grant_log[3][0]}, 64'b0001);
`endif

        // Reset pulse while in RSP of a requester-0 read.
        @(posedge clk); #1;
        grant_log.delete();
        issue(0, 1'b0, 3'd2, 16'h0);
        @(negedge clk);
        @(negedge clk); chk("rst_rsp_gnt0", {63'd0, gnt0}, 64'd1);
        @(posedge clk); #1; drop(0);
        #1; reset = 1'b1;
        #0.5; chk_all_zero("outputs_during_rsp_reset");
        #0.5; reset = 1'b0;
        flush_model();
        @(negedge clk); chk("rst_no_rvalid", {gnt0, gnt1, rvalid0, rvalid1, mem_en}, 64'd0);
        @(negedge clk); chk("rst_idle", {gnt0, gnt1, rvalid0, rvalid1, mem_en}, 64'd0);
        run_traffic(1, 1, 0, 0);
        chk("tie_after_reset_len", grant_log.size(), 2);
        if (grant_log.size() > 0) chk("tie_after_reset", grant_log[0], 0);

        // Random back-to-back and gapped traffic against the reference memory.
        run_traffic(40, 40, 50, 2);
        run_traffic(30, 30, 40, 0);
        run_traffic(20, 5, 60, 1);
        repeat (3) @(negedge clk);
        chk("cmd_queues_drained", cmd_q0.size() + cmd_q1.size(), 0);
        chk("rsp_queue_drained", rsp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 3, sets the data memory word address width.
REQ-002 Parameter DATA_W, default 16, sets the data word width.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req0, req1  input  1 each  access request; requester 0 is the processor load/store port, requester 1 is the loader/debug port.
REQ-006 we0, we1  input  1 each  1 = write, 0 = read; qualified by reqN.
REQ-007 addr0, addr1  input  ADDR_W each  word address.
REQ-008 wdata0, wdata1  input  DATA_W each  write data.
REQ-009 gnt0, gnt1  output  1 each  one-cycle grant pulse; the command is accepted in that cycle.
REQ-010 rvalid0, rvalid1  output  1 each  one-cycle read-data-valid pulse.
REQ-011 rdata  output  DATA_W  read data, valid only while an rvalidN is high.
REQ-012 mem_en, mem_we  output  1 each  memory strobe and write enable.
REQ-013 mem_addr, mem_wdata  output  ADDR_W, DATA_W  memory command.
REQ-014 mem_rdata  input  DATA_W  memory read data, valid in the cycle after a read strobe.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, CMD and RSP.
REQ-016 In IDLE with any reqN high, the arbiter SHALL select a winner, register its we/addr/wdata, and move to CMD on the next edge.
REQ-017 In IDLE with no request, the FSM SHALL stay in IDLE and drive all outputs low.
REQ-018 In CMD, the arbiter SHALL assert mem_en=1, drive mem_we/mem_addr/mem_wdata from the registered command, and pulse gntN of the winner for exactly one cycle.
REQ-019 From CMD, a write SHALL return to IDLE, and a read SHALL go to RSP.
REQ-020 In RSP, rdata SHALL equal mem_rdata, rvalidN of the winner SHALL pulse for one cycle, and the FSM SHALL return to IDLE.
REQ-021 Read latency SHALL be 3 cycles from a sampled request to rvalid (IDLE, CMD, RSP).
REQ-022 Write occupancy SHALL be 2 cycles.
REQ-023 The memory outputs SHALL be low in IDLE and RSP.
REQ-024 gnt0 and gnt1 SHALL never be high together; the same holds for rvalid0 and rvalid1.
REQ-025 A requester SHALL hold reqN high until gntN, and SHALL deassert it or present a new command in the cycle after gntN.
REQ-026 A request that drops after IDLE sampling SHALL still complete, because the command is registered.
REQ-027 A request arriving while the FSM is in CMD or RSP SHALL wait for the next IDLE; it SHALL not be lost or reordered.
REQ-028 A register last_gnt SHALL record the most recent winner.

Reset
REQ-029 Reset SHALL force the FSM to IDLE, set last_gnt=1, and clear the registered command and rdata to 0.
REQ-030 During reset, all outputs SHALL be 0.
REQ-031 Reset in CMD or RSP SHALL abort the access, and no gnt or rvalid pulse SHALL follow after reset release.

Configuration
REQ-032 With ARB_ROUND_ROBIN_EN defined, a tie (both req high in IDLE) SHALL be won by the requester not equal to last_gnt, so the first tie after reset goes to requester 0.
REQ-033 Without ARB_ROUND_ROBIN_EN, requester 0 SHALL always win ties, and last_gnt SHALL still update but not affect selection.
REQ-034 When only one requester is active, it SHALL win in both configurations.

Verification
REQ-035 The bench SHALL cover: req0 read at addr 3 with mem_rdata=16'hA5A5 -> gnt0 at cycle 2, mem_en=1/mem_we=0/mem_addr=3 at cycle 2, rvalid0 with rdata=16'hA5A5 at cycle 3.
REQ-036 The bench SHALL cover: req1 write at addr 7 with wdata1=16'h1234 -> gnt1 with mem_we=1/mem_addr=7/mem_wdata=16'h1234 at cycle 2, then IDLE at cycle 3, and no rvalid.
REQ-037 The bench SHALL cover: req0 and req1 both held continuously for reads with ARB_ROUND_ROBIN_EN defined -> grant order 0,1,0,1; without the macro -> 0,0,0 until req0 drops.
REQ-038 The bench SHALL cover: reset asserted for 1 ns while in RSP -> rvalidN stays 0, the FSM is in IDLE, and the next tie goes to requester 0.
REQ-039 The bench SHALL cover: req0 read dropped one cycle after sampling -> the access still completes with gnt0 and rvalid0.
REQ-040 The bench SHALL cover: random back-to-back traffic checked against a reference memory model -> zero data mismatches and no simultaneous gnt0 and gnt1.
